// File: rtl/cory_ordq4.sv
// Ordered response router: passes arbiter requests to a shared target, queues source tags in order,
// and steers in-order responses back to the originating port. Optional macro: CORY_ORDQ4_ERR_EN.
module cory_ordq4 #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 8,
  parameter int unsigned D = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_a_v,
  input  logic [N-1:0]         i_a_d,
  input  logic [1:0]           i_a_s,
  output logic                 o_a_r,
  output logic                 o_z_v,
  output logic [N-1:0]         o_z_d,
  input  logic                 i_z_r,
  input  logic                 i_b_v,
  input  logic [M-1:0]         i_b_d,
  output logic                 o_b_r,
  output logic                 o_b0_v,
  output logic                 o_b1_v,
  output logic                 o_b2_v,
  output logic                 o_b3_v,
  output logic [M-1:0]         o_b_d,
  input  logic                 i_b0_r,
  input  logic                 i_b1_r,
  input  logic                 i_b2_r,
  input  logic                 i_b3_r,
  output logic [$clog2(D):0]   o_cnt
`ifdef CORY_ORDQ4_ERR_EN
  ,
  output logic                 o_err
`endif
);

  localparam int unsigned AW = $clog2(D);
  localparam int unsigned CW = AW + 1;

  logic [1:0]    q [D];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic [1:0] h;
  logic [3:0] port_r;
  logic       head_r;
  logic       head_v;

  assign full   = (cnt == CW'(D));
  assign empty  = (cnt == '0);
  assign h      = q[rp];
  assign port_r = {i_b3_r, i_b2_r, i_b1_r, i_b0_r};
  assign head_r = port_r[h];
  assign head_v = i_b_v & ~empty;

  // Request path: combinational pass-through gated only by full
  assign o_z_v = i_a_v & ~full;
  assign o_a_r = i_z_r & ~full;
  assign o_z_d = i_a_d;
  assign push  = i_a_v & i_z_r & ~full;

  // Response path: only the head port sees valid
  assign o_b0_v = head_v & (h == 2'd0);
  assign o_b1_v = head_v & (h == 2'd1);
  assign o_b2_v = head_v & (h == 2'd2);
  assign o_b3_v = head_v & (h == 2'd3);
  assign o_b_d  = i_b_d;
  assign pop    = i_b_v & ~empty & head_r;

`ifdef CORY_ORDQ4_ERR_EN
  // Orphan responses on an empty queue are accepted and dropped
  assign o_b_r = (~empty & head_r) | (empty & i_b_v);

  always_ff @(posedge clk) begin
    if (reset) begin
      o_err <= 1'b0;
    end else if (empty & i_b_v) begin
      o_err <= 1'b1;
    end
  end
`else
  assign o_b_r = ~empty & head_r;
`endif

  assign o_cnt = cnt;

  // Tag storage needs no reset; pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) begin
      q[wp] <= i_a_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_cory_ordq4.sv
// Directed testbench for cory_ordq4 (D=4); builds with or without CORY_ORDQ4_ERR_EN.
module tb_cory_ordq4;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_a_v;
  logic [7:0] i_a_d;
  logic [1:0] i_a_s;
  logic       o_a_r;
  logic       o_z_v;
  logic [7:0] o_z_d;
  logic       i_z_r;
  logic       i_b_v;
  logic [7:0] i_b_d;
  logic       o_b_r;
  logic       o_b0_v, o_b1_v, o_b2_v, o_b3_v;
  logic [7:0] o_b_d;
  logic       i_b0_r, i_b1_r, i_b2_r, i_b3_r;
  logic [2:0] o_cnt;
  logic [3:0] bv;
`ifdef CORY_ORDQ4_ERR_EN
  logic       o_err;
`endif

  int n_chk = 0;
  int n_pass = 0;

  assign bv = {o_b3_v, o_b2_v, o_b1_v, o_b0_v};

  always #5 clk = ~clk;

  cory_ordq4 #(.N(8), .M(8), .D(4)) dut (
    .clk(clk), .reset(reset),
    .i_a_v(i_a_v), .i_a_d(i_a_d), .i_a_s(i_a_s), .o_a_r(o_a_r),
    .o_z_v(o_z_v), .o_z_d(o_z_d), .i_z_r(i_z_r),
    .i_b_v(i_b_v), .i_b_d(i_b_d), .o_b_r(o_b_r),
    .o_b0_v(o_b0_v), .o_b1_v(o_b1_v), .o_b2_v(o_b2_v), .o_b3_v(o_b3_v),
    .o_b_d(o_b_d),
    .i_b0_r(i_b0_r), .i_b1_r(i_b1_r), .i_b2_r(i_b2_r), .i_b3_r(i_b3_r),
    .o_cnt(o_cnt)
`ifdef CORY_ORDQ4_ERR_EN
    , .o_err(o_err)
`endif
  );

  // Inputs change at negedge; checks happen 1 time unit later, well before the next posedge.
  task automatic do_reset();
    @(negedge clk);
    i_a_v = 0; i_a_d = 0; i_a_s = 0; i_z_r = 1;
    i_b_v = 0; i_b_d = 0;
    {i_b3_r, i_b2_r, i_b1_r, i_b0_r} = 4'b1111;
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (o_cnt !== 3'd0) $display("FAIL reset_cnt got %0d want 0", o_cnt); else n_pass++;
    n_chk++; if (o_a_r !== 1'b1) $display("FAIL reset_a_r got %b want 1", o_a_r); else n_pass++;
    n_chk++; if (o_b_r !== 1'b0) $display("FAIL reset_b_r got %b want 0", o_b_r); else n_pass++;
    n_chk++; if (bv !== 4'b0000) $display("FAIL reset_bv got %b want 0000", bv); else n_pass++;
`ifdef CORY_ORDQ4_ERR_EN
    n_chk++; if (o_err !== 1'b0) $display("FAIL reset_err got %b want 0", o_err); else n_pass++;
`endif
  endtask

  task automatic test_order();
    logic [1:0] tags [3];
    logic [7:0] rsp  [3];
    logic [3:0] wbv  [3];
    tags = '{2'd2, 2'd0, 2'd3};
    rsp  = '{8'hA1, 8'hA2, 8'hA3};
    wbv  = '{4'b0100, 4'b0001, 4'b1000};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_a_v = 1; i_a_s = tags[i]; i_a_d = 8'h10 + 8'(i);
      #1;
      n_chk++; if (o_z_v !== 1'b1 || o_z_d !== 8'h10 + 8'(i)) $display("FAIL order_zpass%0d got v=%b d=%h", i, o_z_v, o_z_d); else n_pass++;
      n_chk++; if (o_cnt !== 3'(i)) $display("FAIL order_cnt_up%0d got %0d want %0d", i, o_cnt, i); else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_a_v = 0; i_b_v = 1; i_b_d = rsp[i];
      #1;
      n_chk++; if (o_cnt !== 3'(3 - i)) $display("FAIL order_cnt_dn%0d got %0d want %0d", i, o_cnt, 3 - i); else n_pass++;
      n_chk++; if (bv !== wbv[i]) $display("FAIL order_bv%0d got %b want %b", i, bv, wbv[i]); else n_pass++;
      n_chk++; if (o_b_d !== rsp[i] || o_b_r !== 1'b1) $display("FAIL order_bd%0d got d=%h r=%b want d=%h r=1", i, o_b_d, o_b_r, rsp[i]); else n_pass++;
    end
    @(negedge clk);
    i_b_v = 0;
    #1;
    n_chk++; if (o_cnt !== 3'd0) $display("FAIL order_cnt_end got %0d want 0", o_cnt); else n_pass++;
  endtask

  task automatic test_full();
    logic [1:0] tags [4];
    tags = '{2'd1, 2'd3, 2'd0, 2'd2};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      i_a_v = 1; i_a_s = tags[i];
    end
    @(negedge clk);
    #1;
    n_chk++; if (o_cnt !== 3'd4) $display("FAIL full_cnt got %0d want 4", o_cnt); else n_pass++;
    n_chk++; if (o_a_r !== 1'b0 || o_z_v !== 1'b0) $display("FAIL full_block got a_r=%b z_v=%b want 0 0", o_a_r, o_z_v); else n_pass++;
    i_b_v = 1;
    #1;
    n_chk++; if (o_a_r !== 1'b0 || bv !== 4'b0010) $display("FAIL full_popcycle got a_r=%b bv=%b want 0 0010", o_a_r, bv); else n_pass++;
    @(negedge clk);
    i_b_v = 0;
    #1;
    n_chk++; if (o_cnt !== 3'd3 || o_a_r !== 1'b1) $display("FAIL full_release got cnt=%0d a_r=%b want 3 1", o_cnt, o_a_r); else n_pass++;
    i_a_v = 0;
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    i_a_v = 1; i_a_s = 2'd1;
    @(negedge clk);
    i_a_v = 0; i_b_v = 1; i_b_d = 8'h5C; i_b1_r = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (o_b_r !== 1'b0 || bv !== 4'b0010 || o_cnt !== 3'd1) $display("FAIL stall%0d got b_r=%b bv=%b cnt=%0d want 0 0010 1", i, o_b_r, bv, o_cnt); else n_pass++;
      @(negedge clk);
    end
    i_b1_r = 1;
    #1;
    n_chk++; if (o_b_r !== 1'b1) $display("FAIL stall_release got b_r=%b want 1", o_b_r); else n_pass++;
    @(negedge clk);
    i_b_v = 0;
    #1;
    n_chk++; if (o_cnt !== 3'd0 || bv !== 4'b0000) $display("FAIL stall_single_pop got cnt=%0d bv=%b want 0 0000", o_cnt, bv); else n_pass++;
  endtask

  task automatic test_no_bypass();
    do_reset();
    @(negedge clk);
    i_a_v = 1; i_a_s = 2'd3; i_b_v = 1; i_b_d = 8'h77;
    #1;
    n_chk++; if (bv !== 4'b0000) $display("FAIL nobypass_bv got %b want 0000", bv); else n_pass++;
`ifndef CORY_ORDQ4_ERR_EN
    n_chk++; if (o_b_r !== 1'b0) $display("FAIL nobypass_b_r got %b want 0", o_b_r); else n_pass++;
`endif
    @(negedge clk);
    i_a_v = 0;
    #1;
    n_chk++; if (o_cnt !== 3'd1 || bv !== 4'b1000 || o_b_r !== 1'b1) $display("FAIL nobypass_next got cnt=%0d bv=%b b_r=%b want 1 1000 1", o_cnt, bv, o_b_r); else n_pass++;
    @(negedge clk);
    i_b_v = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      i_a_v = 1; i_a_s = 2'(j);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      i_a_v = 1; i_a_s = 2'(k + 2); i_b_v = 1; i_b_d = 8'h30 + 8'(k);
      #1;
      n_chk++; if (o_cnt !== 3'd2) $display("FAIL b2b_cnt%0d got %0d want 2", k, o_cnt); else n_pass++;
      n_chk++; if (bv !== 4'(1 << (k % 4)) || o_b_r !== 1'b1 || o_a_r !== 1'b1) $display("FAIL b2b_hs%0d got bv=%b b_r=%b a_r=%b", k, bv, o_b_r, o_a_r); else n_pass++;
    end
    @(negedge clk);
    i_a_v = 0; i_b_v = 0;
    #1;
    n_chk++; if (o_cnt !== 3'd2) $display("FAIL b2b_cnt_end got %0d want 2", o_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      i_a_v = 1; i_a_s = 2'd2;
    end
    @(negedge clk);
    i_a_v = 0;
    #1;
    n_chk++; if (o_cnt !== 3'd3) $display("FAIL rstmid_pre got %0d want 3", o_cnt); else n_pass++;
    reset = 1; i_b_v = 1;
    @(negedge clk);
    reset = 0;
    #1;
    n_chk++; if (o_cnt !== 3'd0 || bv !== 4'b0000) $display("FAIL rstmid_post got cnt=%0d bv=%b want 0 0000", o_cnt, bv); else n_pass++;
    @(negedge clk);
    i_b_v = 0;
  endtask

  task automatic test_empty_resp();
    do_reset();
    @(negedge clk);
    i_b_v = 1; i_b_d = 8'hEE;
    #1;
    n_chk++; if (bv !== 4'b0000) $display("FAIL empty_bv got %b want 0000", bv); else n_pass++;
`ifdef CORY_ORDQ4_ERR_EN
    n_chk++; if (o_b_r !== 1'b1 || o_err !== 1'b0) $display("FAIL empty_drop got b_r=%b err=%b want 1 0", o_b_r, o_err); else n_pass++;
    @(negedge clk);
    i_b_v = 0;
    #1;
    n_chk++; if (o_err !== 1'b1 || o_cnt !== 3'd0) $display("FAIL empty_err got err=%b cnt=%0d want 1 0", o_err, o_cnt); else n_pass++;
    @(negedge clk);
    #1;
    n_chk++; if (o_err !== 1'b1) $display("FAIL empty_sticky got %b want 1", o_err); else n_pass++;
    do_reset();
    n_chk++; if (o_err !== 1'b0) $display("FAIL empty_err_clr got %b want 0", o_err); else n_pass++;
`else
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (o_b_r !== 1'b0 || o_cnt !== 3'd0) $display("FAIL empty_hold%0d got b_r=%b cnt=%0d want 0 0", i, o_b_r, o_cnt); else n_pass++;
      @(negedge clk);
      #1;
    end
    i_b_v = 0;
`endif
  endtask

  initial begin
    reset = 1;
    i_a_v = 0; i_a_d = 0; i_a_s = 0; i_z_r = 1; i_b_v = 0; i_b_d = 0;
    {i_b3_r, i_b2_r, i_b1_r, i_b0_r} = 4'b1111;
    test_reset();
    test_order();
    test_full();
    test_stall();
    test_no_bypass();
    test_back_to_back();
    test_reset_mid();
    test_empty_resp();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cory_ordq4.md
# cory_ordq4

Ordered response router for the 4-port arbitration tree. Sits directly downstream of the 4-way arbiter. It passes each granted request through to the shared target and records the 2-bit source index in an in-order tag queue. It then steers the target's in-order responses back to the originating port (0..3), backpressuring the arbiter when too many requests are outstanding.

## Interface
- `N`, default 8: request data width.
- `M`, default 8: response data width.
- `D`, default 4: tag queue depth (outstanding requests); power of two, >= 2.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `i_a_v`, in, 1: request valid from arbiter.
- `i_a_d`, in, N: request data from arbiter.
- `i_a_s`, in, 2: source port index of the granted request.
- `o_a_r`, out, 1: request ready to arbiter.
- `o_z_v`, out, 1: request valid to target.
- `o_z_d`, out, N: request data to target (`= i_a_d`).
- `i_z_r`, in, 1: target request ready.
- `i_b_v`, in, 1: response valid from target.
- `i_b_d`, in, M: response data.
- `o_b_r`, out, 1: response ready to target.
- `o_b0_v`..`o_b3_v`, out, 1 each: per-port response valid.
- `o_b_d`, out, M: response data, shared by all ports (`= i_b_d`).
- `i_b0_r`..`i_b3_r`, in, 1 each: per-port response ready.
- `o_cnt`, out, clog2(D)+1: outstanding-tag count.
- `o_err`, out, 1: orphan-response flag. Present only with `CORY_ORDQ4_ERR_EN`.

## Operation
- Tag queue: D entries x 2 bits, write pointer `wp`, read pointer `rp`, count `cnt`. Pointers wrap modulo D. `full = (cnt==D)`, `empty = (cnt==0)`.
- Request path, combinational:
  - `o_z_v = i_a_v & ~full`
  - `o_a_r = i_z_r & ~full`
  - `push = i_a_v & i_z_r & ~full`
  - On push: `q[wp] <= i_a_s`, `wp <= wp+1`.
- Full blocks push even when a pop occurs in the same cycle. There is no ready path from response to request.
- Response path: head tag `h = q[rp]`.
  - `o_bk_v = i_b_v & ~empty & (h==k)`
  - `o_b_r = ~empty & i_b{h}_r`
  - `pop = i_b_v & o_b_r`
  - On pop: `rp <= rp+1`.
- Only the head port may see valid. The other three valids stay 0, even when their readys are high.
- Count update:
  - push only: `cnt+1`
  - pop only: `cnt-1`
  - push and pop together: unchanged; both pointers advance.
- `o_cnt = cnt`. It never exceeds D and never underflows.
- Responses are strictly in request order; no reordering or per-port queues.

## Timing
- Request path: zero latency, purely combinational pass-through.
- A pushed tag reaches the head at the earliest in the next cycle. A response presented in the same cycle as the push into an empty queue is held (`o_b_r=0`) until the next cycle. There is no bypass.
- After any handshake, valid/data must be held stable by the sender until accepted. The block does not register data.
- Reset, with `reset=1` at a rising edge:
  - `wp=rp=0`, `cnt=0`, `o_err=0`.
  - Consequently `o_cnt=0` and `o_a_r=i_z_r`. `o_b_r=0` and all `o_bk_v=0`, except as noted under `CORY_ORDQ4_ERR_EN`.
- Reset mid-operation discards all outstanding tags. Responses to those requests become orphans.
- Full: `o_a_r=0` and `o_z_v=0` until a pop has taken effect, i.e. from the cycle after the pop.

## Configuration
- `CORY_ORDQ4_ERR_EN` undefined:
  - A response arriving with the queue empty is stalled: `o_b_r=0`, no port valid.
  - No `o_err` port.
- `CORY_ORDQ4_ERR_EN` defined:
  - When `empty & i_b_v`, `o_b_r=1` and the response is dropped. No port valid; `cnt` unchanged.
  - `o_err` is set on the next edge and stays sticky until reset.

## Test plan
- D=4, push tags 2,0,3 with `i_z_r=1`, then 3 responses 0xA1,0xA2,0xA3 with all port readys high -> `o_b2_v`/0xA1, `o_b0_v`/0xA2, `o_b3_v`/0xA3 in order; `o_cnt` goes 1,2,3, then 2,1,0.
- Push 4 tags with no response -> `o_cnt=4` and `o_a_r=0`. Pop one -> `o_a_r` returns to high the following cycle.
- Head tag 1 with `i_b1_r=0` and `i_b_v=1` for 3 cycles -> `o_b_r=0`, `o_b1_v=1`, other valids 0, `o_cnt` unchanged. Then raise `i_b1_r` -> a single pop.
- Push and pop in the same cycle at `cnt=2` -> `cnt` stays 2 and the pointers wrap correctly across 8 such cycles.
- Assert `reset` at `cnt=3` -> next cycle `o_cnt=0` and all `o_bk_v=0`.
- Response with the queue empty:
  - without `CORY_ORDQ4_ERR_EN` -> `o_b_r=0`, held;
  - with `CORY_ORDQ4_ERR_EN` -> `o_b_r=1` and `o_err=1` next cycle, sticky until reset.
